shiftreg_seq_ctrl: RTL and testbench
====================================

Name: shiftreg_seq_ctrl

Overview:
Command sequencer for the team's 4-bit universal shift register (select/leftInp/rightInp/INP/OUT datapath).
- Accepts one command per valid/ready handshake: parallel load, logical/arithmetic shift, or rotate by N positions.
- Drives the register's select, serial-fill and parallel-input lines, one shift per clock.
- Reads the register's OUT back to generate rotate and arithmetic fill bits.
- Sits between a host command source and the shift register instance.

Parameters:
- WIDTH, 4, shift register width; must match the attached register.
- AMT_W, 3, width of the shift-amount field; max amount 2**AMT_W-1.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  000 LOAD, 001 SHR, 010 SHL, 011 ROR, 100 ROL, 101 ASR; 110/111 illegal.
- cmd_amt  in  AMT_W  shift count; ignored for LOAD.
- cmd_data  in  WIDTH  parallel data for LOAD.
- abort  in  1  synchronous abort of an in-progress shift.
- sr_out  in  WIDTH  register OUT feedback.
- sr_sel  out  2  register select: 00 hold, 01 shift toward LSB (MSB filled from leftInp), 10 shift toward MSB (LSB filled from rightInp), 11 parallel load.
- sr_inp  out  WIDTH  register INP.
- sr_left  out  1  register leftInp.
- sr_right  out  1  register rightInp.
- busy  out  1  high in any state other than IDLE.
- remaining  out  AMT_W  shifts still to issue.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Reset (async, RST_N=0) forces state IDLE and clears op/count registers and all outputs: sr_sel=00, sr_inp=0, sr_left=0, sr_right=0, remaining=0, done=0, err=0, busy=0, cmd_ready=1 after release.
- States: IDLE, LOAD, SHIFT, DONE.
- cmd_ready=1 only in IDLE. A command is accepted on the rising edge with cmd_valid & cmd_ready. op/amt/data are registered at acceptance; later input changes have no effect.
- IDLE transitions on accept:
  - LOAD -> LOAD.
  - Legal shift op with amt>0 -> SHIFT, remaining=amt.
  - Legal shift op with amt=0 -> DONE directly; no select activity.
  - Illegal op -> stay in IDLE; err=1 for the following cycle; sr_sel stays 00.
- LOAD: lasts exactly one cycle with sr_sel=11 and sr_inp=registered data. Register holds the data after that edge. Then DONE.
- SHIFT: sr_sel is active every cycle; remaining decrements each edge; the edge where remaining goes 1->0 moves to DONE. Exactly amt shift edges are issued.
  - SHR: sel 01, sr_left=0.
  - SHL: sel 10, sr_right=0.
  - ROR: sel 01, sr_left=sr_out[0].
  - ROL: sel 10, sr_right=sr_out[WIDTH-1].
  - ASR: sel 01, sr_left=sr_out[WIDTH-1].
  - Fill bits are combinational from sr_out, so each shift uses the current register value.
- Amounts >= WIDTH are legal: rotates wrap (ROR by WIDTH returns the original value); SHR/SHL clear the register; ASR saturates to all sign bits.
- abort high in SHIFT: no shift on that edge (sr_sel=00 that cycle); go to DONE; remaining=0. abort is ignored in IDLE, LOAD and DONE.
- DONE: one cycle; done=1, sr_sel=00; then IDLE. A new command can be accepted on the cycle after done.
- sr_sel=00 in IDLE and DONE; the register holds.
- Latency: LOAD is 2 cycles from accept edge to done pulse; a shift of amount N is N+1 cycles.
- Reset asserted mid-operation aborts immediately with no done pulse; the register contents are left as they are at reset.

Test Plan:
- Reset, then LOAD cmd_data=1001 -> sr_sel=11, sr_inp=1001 for 1 cycle; done 1 cycle later; register OUT=1001; cmd_ready back to 1.
- From 1001, ROR amt=1 -> OUT=1100 after 1 shift edge; done next cycle. Then ROL amt=2 -> 1001 then 0011.
- From 1001, ASR amt=2 -> 1100, 1110. Then SHL amt=5 -> 0000; remaining counts 5..0; exactly 5 edges with sr_sel=10.
- Shift op with amt=0, then op=111 -> first gives done 1 cycle after accept with sr_sel=00 throughout; illegal op gives err pulse, no done, busy stays 0.
- From 1001, ROR amt=7, abort pulsed after 2 shifts -> OUT=0110; sr_sel=00 on the abort cycle; done the next cycle; remaining=0.
- RST_N low during SHIFT (remaining=3) -> sr_sel=00, busy=0 and done=0 immediately (asynchronous); new LOAD accepted after release.

Source files
------------

// File: rtl/shiftreg_seq_ctrl.sv
// Command sequencer for the 4-bit universal shift register.
// Accepts load/shift/rotate commands and drives select, fill and parallel
// input lines, issuing one shift per clock and reading OUT back for fill bits.
module shiftreg_seq_ctrl #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned AMT_W = 3
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AMT_W-1:0] cmd_amt,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             abort,
   input  logic [WIDTH-1:0] sr_out,
   output logic [1:0]       sr_sel,
   output logic [WIDTH-1:0] sr_inp,
   output logic             sr_left,
   output logic             sr_right,
   output logic             busy,
   output logic [AMT_W-1:0] remaining,
   output logic             done,
   output logic             err
);

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_SHR  = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_ROR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ASR  = 3'b101;

   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_RIGHT = 2'b01;
   localparam logic [1:0] SEL_LEFT  = 2'b10;
   localparam logic [1:0] SEL_LOAD  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_LOAD  = 2'b01,
      S_SHIFT = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic             err_q, err_d;
   logic             legal_shift;

   // Only the end bits of OUT feed the fill logic; the middle bits are unused.
   logic unused_sr_mid;
   assign unused_sr_mid = &{1'b0, sr_out};

   assign legal_shift = (cmd_op >= OP_SHR) && (cmd_op <= OP_ASR);

   // State and command registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         op_q    <= OP_LOAD;
         data_q  <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: command acceptance, shift counting and abort.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      rem_d   = rem_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_op == OP_LOAD) begin
                  op_d    = cmd_op;
                  data_d  = cmd_data;
                  rem_d   = '0;
                  state_d = S_LOAD;
               end else if (legal_shift) begin
                  op_d    = cmd_op;
                  rem_d   = cmd_amt;
                  state_d = (cmd_amt == '0) ? S_DONE : S_SHIFT;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_LOAD:  state_d = S_DONE;
         S_SHIFT: begin
            if (abort) begin
               rem_d   = '0;
               state_d = S_DONE;
            end else begin
               rem_d = rem_q - AMT_W'(1);
               if (rem_q == AMT_W'(1)) state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Register control lines, decoded from state; fill bits follow live OUT.
   always_comb begin
      sr_sel   = SEL_HOLD;
      sr_inp   = '0;
      sr_left  = 1'b0;
      sr_right = 1'b0;
      case (state_q)
         S_LOAD: begin
            sr_sel = SEL_LOAD;
            sr_inp = data_q;
         end
         S_SHIFT: begin
            if (!abort) begin
               case (op_q)
                  OP_SHR: sr_sel = SEL_RIGHT;
                  OP_SHL: sr_sel = SEL_LEFT;
                  OP_ROR: begin
                     sr_sel  = SEL_RIGHT;
                     sr_left = sr_out[0];
                  end
                  OP_ROL: begin
                     sr_sel   = SEL_LEFT;
                     sr_right = sr_out[WIDTH-1];
                  end
                  OP_ASR: begin
                     sr_sel  = SEL_RIGHT;
                     sr_left = sr_out[WIDTH-1];
                  end
                  default: sr_sel = SEL_HOLD;
               endcase
            end
         end
         default: sr_sel = SEL_HOLD;
      endcase
   end

   // Host-facing status derived from registered state.
   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign remaining = rem_q;
   assign err       = err_q;

endmodule

// File: tb/tb_shiftreg_seq_ctrl.sv
// Directed bench for shiftreg_seq_ctrl with a behavioural 4-bit universal
// shift register attached to the controller's select/fill/INP lines.
module tb_shiftreg_seq_ctrl;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned AMT_W = 3;

   logic             CLK = 1'b0;
   logic             RST_N = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = 3'b000;
   logic [AMT_W-1:0] cmd_amt = '0;
   logic [WIDTH-1:0] cmd_data = '0;
   logic             abort = 1'b0;
   logic [WIDTH-1:0] sr_out = '0;
   logic [1:0]       sr_sel;
   logic [WIDTH-1:0] sr_inp;
   logic             sr_left;
   logic             sr_right;
   logic             busy;
   logic [AMT_W-1:0] remaining;
   logic             done;
   logic             err;

   int passed = 0;
   int total  = 0;

   shiftreg_seq_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data),
      .abort(abort), .sr_out(sr_out),
      .sr_sel(sr_sel), .sr_inp(sr_inp), .sr_left(sr_left), .sr_right(sr_right),
      .busy(busy), .remaining(remaining), .done(done), .err(err)
   );

   always #5 CLK = ~CLK;

   // Universal shift register: 01 toward LSB, 10 toward MSB, 11 load.
   always @(posedge CLK) begin
      case (sr_sel)
         2'b01:   sr_out <= {sr_left, sr_out[WIDTH-1:1]};
         2'b10:   sr_out <= {sr_out[WIDTH-2:0], sr_right};
         2'b11:   sr_out <= sr_inp;
         default: sr_out <= sr_out;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // One accept edge, then scramble the command inputs.
   task automatic issue(input logic [2:0] op, input logic [2:0] amt, input logic [3:0] data);
      cmd_op    = op;
      cmd_amt   = amt;
      cmd_data  = data;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      cmd_op    = 3'b110;
      cmd_amt   = 3'd7;
      cmd_data  = 4'hF;
   endtask

   initial begin
      // Reset state
      step();
      step();
      chk("rst_sel", 32'(sr_sel), 32'h0);
      chk("rst_inp", 32'(sr_inp), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_rem", 32'(remaining), 32'h0);
      RST_N = 1'b1;
      step();
      chk("rst_ready", 32'(cmd_ready), 32'h1);

      // LOAD 1001
      issue(3'b000, 3'd0, 4'b1001);
      chk("ld_sel", 32'(sr_sel), 32'h3);
      chk("ld_inp", 32'(sr_inp), 32'h9);
      chk("ld_ready", 32'(cmd_ready), 32'h0);
      chk("ld_busy", 32'(busy), 32'h1);
      step();
      chk("ld_done", 32'(done), 32'h1);
      chk("ld_out", 32'(sr_out), 32'h9);
      chk("ld_dsel", 32'(sr_sel), 32'h0);
      step();
      chk("ld_ready2", 32'(cmd_ready), 32'h1);
      chk("ld_done2", 32'(done), 32'h0);

      // ROR 1: 1001 -> 1100
      issue(3'b011, 3'd1, 4'h0);
      chk("ror_sel", 32'(sr_sel), 32'h1);
      chk("ror_left", 32'(sr_left), 32'h1);
      step();
      chk("ror_out", 32'(sr_out), 32'hC);
      chk("ror_done", 32'(done), 32'h1);
      step();

      // ROL 2: 1100 -> 1001 -> 0011
      issue(3'b100, 3'd2, 4'h0);
      chk("rol_sel", 32'(sr_sel), 32'h2);
      chk("rol_rem", 32'(remaining), 32'h2);
      step();
      chk("rol_out1", 32'(sr_out), 32'h9);
      chk("rol_rem1", 32'(remaining), 32'h1);
      step();
      chk("rol_out2", 32'(sr_out), 32'h3);
      chk("rol_done", 32'(done), 32'h1);
      step();

      // LOAD 1001 then ASR 2: 1100, 1110
      issue(3'b000, 3'd0, 4'b1001);
      step();
      step();
      issue(3'b101, 3'd2, 4'h0);
      chk("asr_sel", 32'(sr_sel), 32'h1);
      step();
      chk("asr_out1", 32'(sr_out), 32'hC);
      step();
      chk("asr_out2", 32'(sr_out), 32'hE);
      chk("asr_done", 32'(done), 32'h1);
      step();

      // SHL 5: remaining 5..1 with select 10, then clear
      issue(3'b010, 3'd5, 4'h0);
      for (int i = 0; i < 5; i++) begin
         chk("shl_rem", 32'(remaining), 32'(5 - i));
         chk("shl_sel", 32'(sr_sel), 32'h2);
         step();
      end
      chk("shl_done", 32'(done), 32'h1);
      chk("shl_rem0", 32'(remaining), 32'h0);
      chk("shl_out", 32'(sr_out), 32'h0);
      chk("shl_dsel", 32'(sr_sel), 32'h0);
      step();

      // SHR amt=0: straight to DONE with no select activity
      issue(3'b001, 3'd0, 4'h0);
      chk("z_done", 32'(done), 32'h1);
      chk("z_sel", 32'(sr_sel), 32'h0);
      chk("z_out", 32'(sr_out), 32'h0);
      step();
      chk("z_ready", 32'(cmd_ready), 32'h1);

      // Illegal op 111: err pulse, no done, stays idle
      issue(3'b111, 3'd3, 4'h0);
      chk("il_err", 32'(err), 32'h1);
      chk("il_busy", 32'(busy), 32'h0);
      chk("il_done", 32'(done), 32'h0);
      chk("il_sel", 32'(sr_sel), 32'h0);
      step();
      chk("il_err2", 32'(err), 32'h0);
      chk("il_done2", 32'(done), 32'h0);

      // LOAD 1001, ROR 7 aborted after 2 shifts -> 0110
      issue(3'b000, 3'd0, 4'b1001);
      step();
      step();
      issue(3'b011, 3'd7, 4'h0);
      chk("ab_rem", 32'(remaining), 32'h7);
      step();
      step();
      chk("ab_out", 32'(sr_out), 32'h6);
      chk("ab_rem5", 32'(remaining), 32'h5);
      abort = 1'b1;
      #1;
      chk("ab_sel", 32'(sr_sel), 32'h0);
      step();
      abort = 1'b0;
      chk("ab_done", 32'(done), 32'h1);
      chk("ab_rem0", 32'(remaining), 32'h0);
      chk("ab_out2", 32'(sr_out), 32'h6);
      step();

      // Abort ignored outside SHIFT: LOAD with abort high still completes
      abort = 1'b1;
      issue(3'b000, 3'd0, 4'b1001);
      chk("abl_sel", 32'(sr_sel), 32'h3);
      step();
      abort = 1'b0;
      chk("abl_out", 32'(sr_out), 32'h9);
      step();

      // Reset during SHIFT with remaining=3
      issue(3'b011, 3'd5, 4'h0);
      step();
      step();
      chk("rr_rem", 32'(remaining), 32'h3);
      RST_N = 1'b0;
      #1;
      chk("rr_sel", 32'(sr_sel), 32'h0);
      chk("rr_busy", 32'(busy), 32'h0);
      chk("rr_done", 32'(done), 32'h0);
      chk("rr_rem0", 32'(remaining), 32'h0);
      step();
      chk("rr_out", 32'(sr_out), 32'h6);
      RST_N = 1'b1;
      step();
      issue(3'b000, 3'd0, 4'b0101);
      chk("rr_ld", 32'(sr_sel), 32'h3);
      step();
      chk("rr_ldone", 32'(done), 32'h1);
      chk("rr_lout", 32'(sr_out), 32'h5);
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
